multicycle_control_fsm: RTL and testbench

Main control unit for the 64-bit multi-cycle computer. Sequences one shared ALU, one shared instruction/data memory port and the register file through fetch, decode, execute, memory and write-back steps. Drives every datapath strobe and mux select, and waits on a memory-ready handshake. Also reports halt/illegal status and a retired-instruction count that the top-level `program_out` debug path can expose.

---
 rtl/multicycle_control_fsm.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the 64-bit multi-cycle core.
// Define MC_CTRL_MUL_EN to build the MUL_BUSY sequencing path.
module multicycle_control_fsm #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic [1:0]  wb_sel,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        mul_start,
    output logic        halted,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_retired
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        MUL_BUSY = 4'd11,
        HALT     = 4'd12,
        ILLEGAL  = 4'd13
    } state_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_t state_q;
    logic   dst_rd_q;
    logic   wb_mul_q;
    logic   unused_in;

`ifdef MC_CTRL_MUL_EN
    logic [3:0] mul_cnt_q;
    assign unused_in = zero;
`else
    assign unused_in = zero ^ (^MUL_LOAD);
`endif

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= FETCH;
            instr_retired <= '0;
            halted        <= 1'b0;
            illegal       <= 1'b0;
            dst_rd_q      <= 1'b0;
            wb_mul_q      <= 1'b0;
`ifdef MC_CTRL_MUL_EN
            mul_cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) state_q <= DECODE;
                end
                DECODE: begin
                    case (opcode)
                        4'd0: state_q <= EXEC_R;
                        4'd1: state_q <= EXEC_I;
                        4'd2, 4'd3: state_q <= MEM_ADDR;
                        4'd4: state_q <= BRANCH;
                        4'd5: state_q <= JUMP;
                        4'd6: begin
                            state_q <= HALT;
                            halted  <= 1'b1;
                        end
`ifdef MC_CTRL_MUL_EN
                        4'd7: begin
                            state_q   <= MUL_BUSY;
                            mul_cnt_q <= MUL_LOAD;
                        end
`endif
                        default: begin
                            state_q <= ILLEGAL;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                EXEC_R: begin
                    state_q  <= ALU_WB;
                    dst_rd_q <= 1'b1;
                    wb_mul_q <= 1'b0;
                end
                EXEC_I: begin
                    state_q  <= ALU_WB;
                    dst_rd_q <= 1'b0;
                    wb_mul_q <= 1'b0;
                end
                MEM_ADDR: begin
                    state_q <= (opcode == 4'd2) ? MEM_RD : MEM_WR;
                end
                MEM_RD: begin
                    if (mem_ready) state_q <= MEM_WB;
                end
                MEM_WR: begin
                    if (mem_ready) begin
                        state_q       <= FETCH;
                        instr_retired <= instr_retired + 32'd1;
                    end
                end
                ALU_WB, MEM_WB, BRANCH, JUMP: begin
                    state_q       <= FETCH;
                    instr_retired <= instr_retired + 32'd1;
                end
`ifdef MC_CTRL_MUL_EN
                MUL_BUSY: begin
                    if (mul_cnt_q == 4'd0) begin
                        state_q  <= ALU_WB;
                        dst_rd_q <= 1'b1;
                        wb_mul_q <= 1'b1;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 4'd1;
                    end
                end
`endif
                HALT:    state_q <= HALT;
                ILLEGAL: state_q <= ILLEGAL;
                default: begin
                    state_q <= ILLEGAL;
                    illegal <= 1'b1;
                end
            endcase
        end
    end

    // Strobes decode from the state register; reset low masks everything.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        wb_sel        = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        mul_start     = 1'b0;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: alu_src_b = 2'd2;
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'd2;
                end
                EXEC_I, MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                MEM_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = 2'd1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = dst_rd_q;
                    wb_sel    = wb_mul_q ? 2'd2 : 2'd0;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'd1;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
`ifdef MC_CTRL_MUL_EN
                MUL_BUSY: mul_start = (mul_cnt_q == MUL_LOAD);
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Reference model expands each instruction into its expected cycle list.
module tb_multicycle_control_fsm;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic        ir_write, reg_write, reg_dst, alu_src_a, mul_start;
    logic [1:0]  wb_sel, alu_src_b, alu_op, pc_source;
    logic        halted, illegal;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    multicycle_control_fsm #(.MUL_LATENCY(ML)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source),
        .mul_start(mul_start), .halted(halted),
        .illegal(illegal), .state(state),
        .instr_retired(instr_retired)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned model_cnt = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       rdy;
        logic       first;
    } cyc_t;

    cyc_t exp_q[$];

    logic [17:0] strobes;
    logic [23:0] obs_all;
    assign strobes = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                      ir_write, reg_write, reg_dst, wb_sel, alu_src_a,
                      alu_src_b, alu_op, pc_source, mul_start};
    assign obs_all = {state, halted, illegal, strobes};

    function automatic cyc_t mk(int st, bit r, bit f);
        cyc_t c;
        c.st = 4'(st);
        c.rdy = r;
        c.first = f;
        return c;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit mul_on();
`ifdef MC_CTRL_MUL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit retires(int op);
        return (op >= 0 && op <= 5) || (op == 7 && mul_on());
    endfunction

    // Expected strobes for one cycle, straight from the per-state table.
    function automatic logic [17:0] exp_out(cyc_t c, int op);
        logic pw, pwc, io, mr, mw, iw, rw, rd, sa, ms;
        logic [1:0] wb, sb, ao, ps;
        {pw, pwc, io, mr, mw, iw, rw, rd, sa, ms} = '0;
        {wb, sb, ao, ps} = '0;
        case (c.st)
            4'd0: begin mr = 1; sb = 1; iw = c.rdy; pw = c.rdy; end
            4'd1: sb = 2;
            4'd2: begin sa = 1; ao = 2; end
            4'd3, 4'd4: begin sa = 1; sb = 2; end
            4'd5: begin mr = 1; io = 1; end
            4'd6: begin rw = 1; wb = 1; end
            4'd7: begin mw = 1; io = 1; end
            4'd8: begin
                rw = 1;
                rd = (op != 1);
                wb = (op == 7) ? 2'd2 : 2'd0;
            end
            4'd9: begin sa = 1; ao = 1; pwc = 1; ps = 1; end
            4'd10: begin pw = 1; ps = 2; end
            4'd11: ms = c.first;
            default: ;
        endcase
        return {pw, pwc, io, mr, mw, iw, rw, rd, wb, sa, sb, ao, ps, ms};
    endfunction

    function automatic logic [23:0] exp_all(cyc_t c, int op);
        return {c.st, c.st == 4'd12, c.st == 4'd13, exp_out(c, op)};
    endfunction

    // Expand one instruction: fs fetch stalls, ms memory stalls.
    function automatic void build(int op, int fs, int ms);
        exp_q.delete();
        repeat (fs) exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(0, 1, 0));
        exp_q.push_back(mk(1, rb(), 0));
        case (op)
            0: begin exp_q.push_back(mk(2, rb(), 0)); exp_q.push_back(mk(8, rb(), 0)); end
            1: begin exp_q.push_back(mk(3, rb(), 0)); exp_q.push_back(mk(8, rb(), 0)); end
            2: begin
                exp_q.push_back(mk(4, rb(), 0));
                repeat (ms) exp_q.push_back(mk(5, 0, 0));
                exp_q.push_back(mk(5, 1, 0));
                exp_q.push_back(mk(6, rb(), 0));
            end
            3: begin
                exp_q.push_back(mk(4, rb(), 0));
                repeat (ms) exp_q.push_back(mk(7, 0, 0));
                exp_q.push_back(mk(7, 1, 0));
            end
            4: exp_q.push_back(mk(9, rb(), 0));
            5: exp_q.push_back(mk(10, rb(), 0));
            6: repeat (20) exp_q.push_back(mk(12, rb(), 0));
            default: begin
                if (op == 7 && mul_on()) begin
                    for (int k = 0; k < ML; k++)
                        exp_q.push_back(mk(11, rb(), k == 0));
                    exp_q.push_back(mk(8, rb(), 0));
                end else begin
                    repeat (20) exp_q.push_back(mk(13, rb(), 0));
                end
            end
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = rb();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        opcode = 4'd0;
        zero = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = (i == 0) ? 1'b1 : rb();
            #1;
            n_tests++;
            if (obs_all !== 24'h0 || instr_retired !== 32'd0) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h cnt %0d, want 0 cnt 0",
                         i, obs_all, instr_retired);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int op = 0;
        build(op, 0, 0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            mem_ready = exp_q[i].rdy;
            opcode = 4'(op);
            zero = rb();
            #1;
            n_tests++;
            if (obs_all !== exp_all(exp_q[i], op)) begin
                n_fail++;
                $display("FAIL add cyc %0d: got %h, want %h",
                         i, obs_all, exp_all(exp_q[i], op));
            end
        end
        @(posedge clk);
        #1;
        model_cnt++;
        n_tests++;
        if (state !== 4'd0 || instr_retired !== model_cnt) begin
            n_fail++;
            $display("FAIL add_retire: state %0d cnt %0d, want 0 cnt %0d",
                     state, instr_retired, model_cnt);
        end
    endtask

    task automatic test_ld_stall();
        int op = 2;
        int held = 0;
        build(op, 0, 3);
        foreach (exp_q[i]) begin
            @(negedge clk);
            mem_ready = exp_q[i].rdy;
            opcode = 4'(op);
            zero = rb();
            #1;
            if (mem_read && iord) held++;
            n_tests++;
            if (obs_all !== exp_all(exp_q[i], op)) begin
                n_fail++;
                $display("FAIL ld_stall cyc %0d: got %h, want %h",
                         i, obs_all, exp_all(exp_q[i], op));
            end
        end
        @(posedge clk);
        #1;
        model_cnt++;
        n_tests++;
        if (held != 4 || state !== 4'd0 || instr_retired !== model_cnt) begin
            n_fail++;
            $display("FAIL ld_stall_end: held %0d state %0d cnt %0d, want 4 0 %0d",
                     held, state, instr_retired, model_cnt);
        end
    endtask

    task automatic test_beq_jmp();
        do_reset();
        for (int n = 0; n < 2; n++) begin
            int op = 4 + n;
            build(op, n, 0);
            foreach (exp_q[i]) begin
                @(negedge clk);
                mem_ready = exp_q[i].rdy;
                opcode = 4'(op);
                zero = 1'b1;
                #1;
                n_tests++;
                if (obs_all !== exp_all(exp_q[i], op)) begin
                    n_fail++;
                    $display("FAIL beq_jmp op %0d cyc %0d: got %h, want %h",
                             op, i, obs_all, exp_all(exp_q[i], op));
                end
            end
            @(posedge clk);
            #1;
            model_cnt++;
        end
        n_tests++;
        if (instr_retired !== 32'd2) begin
            n_fail++;
            $display("FAIL beq_jmp_count: got %0d, want 2", instr_retired);
        end
    endtask

    task automatic test_halt_illegal();
        for (int n = 0; n < 2; n++) begin
            int op = (n == 0) ? 9 : 6;
            do_reset();
            build(op, 0, 0);
            foreach (exp_q[i]) begin
                @(negedge clk);
                mem_ready = exp_q[i].rdy;
                opcode = (i >= 2) ? 4'($urandom) : 4'(op);
                zero = rb();
                #1;
                n_tests++;
                if (obs_all !== exp_all(exp_q[i], op)) begin
                    n_fail++;
                    $display("FAIL absorb op %0d cyc %0d: got %h, want %h",
                             op, i, obs_all, exp_all(exp_q[i], op));
                end
            end
            n_tests++;
            if (instr_retired !== 32'd0) begin
                n_fail++;
                $display("FAIL absorb_count op %0d: got %0d, want 0",
                         op, instr_retired);
            end
        end
        do_reset();
    endtask

    task automatic test_mul();
        int op = 7;
        int pulses = 0;
        build(op, 0, 0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            mem_ready = exp_q[i].rdy;
            opcode = 4'(op);
            zero = rb();
            #1;
            if (mul_start) pulses++;
            n_tests++;
            if (obs_all !== exp_all(exp_q[i], op)) begin
                n_fail++;
                $display("FAIL mul cyc %0d: got %h, want %h",
                         i, obs_all, exp_all(exp_q[i], op));
            end
        end
        if (retires(op)) begin
            @(posedge clk);
            #1;
            model_cnt++;
        end
        n_tests++;
        if (pulses != int'(mul_on()) || instr_retired !== model_cnt) begin
            n_fail++;
            $display("FAIL mul_end: pulses %0d cnt %0d, want %0d cnt %0d",
                     pulses, instr_retired, mul_on(), model_cnt);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int op = $urandom_range(0, 6);
            if (op == 6) op = mul_on() ? 7 : 1;
            build(op, $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (exp_q[i]) begin
                @(negedge clk);
                mem_ready = exp_q[i].rdy;
                opcode = 4'(op);
                zero = rb();
                #1;
                n_tests++;
                if (obs_all !== exp_all(exp_q[i], op)) begin
                    n_fail++;
                    $display("FAIL random %0d op %0d cyc %0d: got %h, want %h",
                             n, op, i, obs_all, exp_all(exp_q[i], op));
                end
            end
            @(posedge clk);
            #1;
            model_cnt++;
        end
        n_tests++;
        if (instr_retired !== model_cnt) begin
            n_fail++;
            $display("FAIL random_count: got %0d, want %0d",
                     instr_retired, model_cnt);
        end
    endtask

    task automatic test_reset_abort();
        int op = 3;
        do_reset();
        force dut.instr_retired = 32'hFFFF_FFFE;
        #1;
        release dut.instr_retired;
        build(op, 0, 2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = exp_q[i].rdy;
            opcode = 4'(op);
            zero = rb();
            #1;
            n_tests++;
            if (obs_all !== exp_all(exp_q[i], op)) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %h, want %h",
                         i, obs_all, exp_all(exp_q[i], op));
            end
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd7 || strobes !== 18'h0) begin
            n_fail++;
            $display("FAIL abort_mask: state %0d strobes %h, want 7 0",
                     state, strobes);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (state !== 4'd0 || instr_retired !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_state: state %0d cnt %h, want 0 0",
                     state, instr_retired);
        end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        model_cnt = 0;
    endtask

    task automatic test_wrap();
        int op = 5;
        force dut.instr_retired = 32'hFFFF_FFFF;
        #1;
        release dut.instr_retired;
        model_cnt = 32'hFFFF_FFFF;
        build(op, 1, 0);
        foreach (exp_q[i]) begin
            @(negedge clk);
            mem_ready = exp_q[i].rdy;
            opcode = 4'(op);
            zero = rb();
            #1;
            n_tests++;
            if (obs_all !== exp_all(exp_q[i], op)) begin
                n_fail++;
                $display("FAIL wrap cyc %0d: got %h, want %h",
                         i, obs_all, exp_all(exp_q[i], op));
            end
        end
        @(posedge clk);
        #1;
        model_cnt++;
        n_tests++;
        if (instr_retired !== model_cnt || model_cnt != 0) begin
            n_fail++;
            $display("FAIL wrap_count: got %h, want 0", instr_retired);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ld_stall();
        test_beq_jmp();
        test_halt_illegal();
        test_mul();
        test_random();
        test_reset_abort();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
